sv32_page_walker: RTL
=====================

Name: sv32_page_walker

Overview:
- Hardware Sv32 page-table walker; the responder that services TLB miss requests.
- Takes a VPN from the TLB and reads up to two PTEs over a generic memory bus.
- Returns the leaf PTE, its level, or a page-fault indication.
- Uses the satp and current privilege level supplied by the priv block; its fault output feeds the TLB fault path to the hazard unit.

Parameters:
- PADDR_W, 32, width of the emitted physical address; PPN bits above PADDR_W-12 must be zero.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- satp  in  32  {mode[31], asid[30:22], ppn[21:0]}
- curr_privilege_level  in  2  U=0, S=1, M=3
- walk_req  in  1  TLB miss request, sampled in IDLE only
- walk_vpn  in  20  virtual page number {vpn1[19:10], vpn0[9:0]}
- walk_acc  in  2  0=load, 1=store, 2=fetch
- walk_flush  in  1  abort the current walk (sfence/context switch)
- walk_busy  out  1  high whenever state != IDLE
- walk_done  out  1  one-cycle completion pulse
- walk_fault  out  1  valid with walk_done; page fault
- walk_pte  out  32  leaf PTE, valid with walk_done and !walk_fault
- walk_mega  out  1  leaf found at level 1 (4 MiB page)
- mem_ren  out  1  PTE read request
- mem_addr  out  PADDR_W  PTE physical address
- mem_rdata  in  32  read data, valid in the cycle mem_busy is low
- mem_busy  in  1  memory stall; a read completes in a cycle with mem_ren=1 and mem_busy=0

Behaviour:
- Clocking and reset: one clock, CLK. Reset is nRST, asynchronous and active-low. On reset:
  - state = IDLE;
  - all outputs 0, latched vpn/acc/pte = 0.
- States: IDLE, L1, L0, RESP.
- IDLE:
  - On walk_req, latch walk_vpn, walk_acc, satp.ppn, privilege.
  - If satp.mode=0 or privilege=M: go to RESP with fault=1 and no memory access (illegal request).
  - Otherwise go to L1.
- L1:
  - mem_ren=1.
  - mem_addr = {satp.ppn,12'b0} + {vpn1,2'b0}.
  - Hold both until mem_busy=0, then evaluate the PTE.
- L0:
  - mem_ren=1.
  - mem_addr = {pte.ppn,12'b0} + {vpn0,2'b0}.
  - Hold until mem_busy=0, then evaluate.
- Address width: if ppn bits [21:PADDR_W-12] are nonzero, go to RESP with fault, with no memory access.
- PTE evaluation, in priority order:
  - V=0, or (R=0 and W=1): fault.
  - R=0 and X=0: pointer. At L1, go to L0. At L0, fault.
  - Leaf at L1 with ppn[9:0] != 0: fault (misaligned superpage).
  - Permission fault:
    - fetch requires X;
    - load requires R;
    - store requires W.
  - Privilege fault:
    - U-mode requires U=1;
    - S-mode requires U=0 (no SUM/MXR support).
  - A=0, or (store and D=0): fault. No hardware A/D update.
  - Otherwise success: walk_pte = PTE, walk_mega = 1 if the leaf was at L1.
- RESP:
  - walk_done=1 for exactly one cycle, with walk_fault, walk_pte, walk_mega valid.
  - Go to IDLE next cycle.
  - On fault, walk_pte=0 and walk_mega=0.
- Latency, zero-wait memory:
  - 4 KiB hit: req at cycle 0; done at cycle 3.
  - Megapage: done at cycle 2.
  - Illegal request: done at cycle 1.
  - Each busy cycle adds one cycle.
- Flush:
  - walk_flush in any state other than IDLE: return to IDLE next cycle.
  - mem_ren drops that same next cycle; no walk_done is produced.
  - Flush in RESP suppresses the pulse.
  - Flush in IDLE with walk_req present: flush wins and the request is dropped.
- Back-to-back requests:
  - walk_req is ignored while busy.
  - A new request is accepted in the IDLE cycle after RESP.
- satp/privilege changes mid-walk have no effect (values are latched); software must flush.

Test Plan:
1. 4 KiB S-mode load:
   - Stimulus: satp=0x8000_0100, priv=S, vpn=0x12345, acc=load. L1 read of 0x0010_0120 returns 0x0008_0001. L0 read of 0x0020_0D14 returns 0x000C_0043.
   - Response: done at cycle 3, fault=0, pte=0x000C_0043, mega=0.
2. Megapage store:
   - Stimulus: same satp, vpn=0x12345, acc=store, L1 returns 0x0040_00C7.
   - Response: done at cycle 2, fault=0, mega=1, exactly one memory read.
3. Faults:
   - L1 returns 0x0040_0447 (misaligned): fault=1.
   - L1 returns 0x0000_0004 (V=0): fault=1.
   - L0 pointer PTE 0x000C_0001: fault=1.
   - Store to a leaf with D=0 (0x000C_0047): fault=1.
   - U-mode load of a leaf with U=0: fault=1.
4. Illegal request:
   - Stimulus: satp=0x0000_0100 or priv=M, with walk_req.
   - Response: done+fault at cycle 1, mem_ren never asserted.
5. Stalls:
   - Stimulus: mem_busy high for 3 cycles on each read.
   - Response: mem_addr and mem_ren stable while stalled; done at cycle 9; rdata ignored while busy.
6. Flush and reset:
   - walk_flush during an L0 stall: IDLE next cycle, no done, a new request accepted.
   - nRST low mid-walk: all outputs 0 immediately.

Source files
------------

// File: rtl/sv32_page_walker.sv
// Sv32 hardware page-table walker: services TLB misses with up to two PTE reads
// and returns the leaf PTE, its level, or a page fault.
module sv32_page_walker #(
    parameter int unsigned PADDR_W = 32
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic [31:0]        satp,
    input  logic [1:0]         curr_privilege_level,
    input  logic               walk_req,
    input  logic [19:0]        walk_vpn,
    input  logic [1:0]         walk_acc,
    input  logic               walk_flush,
    output logic               walk_busy,
    output logic               walk_done,
    output logic               walk_fault,
    output logic [31:0]        walk_pte,
    output logic               walk_mega,
    output logic               mem_ren,
    output logic [PADDR_W-1:0] mem_addr,
    input  logic [31:0]        mem_rdata,
    input  logic               mem_busy
);

    localparam int unsigned PPN_W    = 22;
    localparam int unsigned FULL_W   = 34;
    localparam int unsigned PPN_KEEP = PADDR_W - 12;
    localparam logic [PPN_W-1:0] PPN_HI_MASK = ~((22'd1 << PPN_KEEP) - 22'd1);

    localparam logic [1:0] ACC_LOAD  = 2'd0;
    localparam logic [1:0] ACC_STORE = 2'd1;
    localparam logic [1:0] ACC_FETCH = 2'd2;
    localparam logic [1:0] PRIV_U    = 2'd0;
    localparam logic [1:0] PRIV_S    = 2'd1;
    localparam logic [1:0] PRIV_M    = 2'd3;

    typedef enum logic [1:0] {IDLE, L1, L0, RESP} state_t;

    state_t             state_q, state_d;
    logic [9:0]         vpn0_q;
    logic [1:0]         acc_q, priv_q;
    logic               done_q;
    logic               busy_d, ren_d, done_d, fault_d, mega_d, latch_req;
    logic [PADDR_W-1:0] addr_d;
    logic [31:0]        pte_d;
    logic [FULL_W-1:0]  l1_full, l0_full;
    logic               pte_fault, pte_ptr, perm_ok, priv_ok;
    logic               unused_bits;

    // ASID, RSW and G carry no meaning for the walk itself
    assign unused_bits = ^{satp[30:22], mem_rdata[9:8], mem_rdata[5]};

    function automatic logic ppn_fits(input logic [PPN_W-1:0] p);
        return (p & PPN_HI_MASK) == 22'd0;
    endfunction

    assign l1_full = {satp[21:0], 12'd0} + {22'd0, walk_vpn[19:10], 2'b00};
    assign l0_full = {mem_rdata[31:10], 12'd0} + {22'd0, vpn0_q, 2'b00};

    // A flush during the response cycle swallows the completion pulse
    assign walk_done = done_q & ~walk_flush;

    // PTE checks on the word returned by the current read
    always_comb begin
        perm_ok = 1'b0;
        case (acc_q)
            ACC_LOAD:  perm_ok = mem_rdata[1];
            ACC_STORE: perm_ok = mem_rdata[2];
            ACC_FETCH: perm_ok = mem_rdata[3];
            default:   perm_ok = 1'b0;
        endcase
        priv_ok = (priv_q == PRIV_U) ? mem_rdata[4] :
                  (priv_q == PRIV_S) ? ~mem_rdata[4] : 1'b0;
        pte_fault = 1'b0;
        pte_ptr   = 1'b0;
        if (!mem_rdata[0] || (!mem_rdata[1] && mem_rdata[2])) begin
            pte_fault = 1'b1;
        end else if (!mem_rdata[1] && !mem_rdata[3]) begin
            if (state_q == L1) pte_ptr = 1'b1;
            else               pte_fault = 1'b1;
        end else if (state_q == L1 && mem_rdata[19:10] != 10'd0) begin
            pte_fault = 1'b1;
        end else if (!perm_ok || !priv_ok) begin
            pte_fault = 1'b1;
        end else if (!mem_rdata[6] || (acc_q == ACC_STORE && !mem_rdata[7])) begin
            pte_fault = 1'b1;
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_d   = state_q;
        ren_d     = 1'b0;
        addr_d    = mem_addr;
        done_d    = 1'b0;
        fault_d   = 1'b0;
        pte_d     = 32'd0;
        mega_d    = 1'b0;
        latch_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (walk_req && !walk_flush) begin
                    latch_req = 1'b1;
                    if (!satp[31] || curr_privilege_level == PRIV_M || !ppn_fits(satp[21:0])) begin
                        state_d = RESP;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                    end else begin
                        state_d = L1;
                        ren_d   = 1'b1;
                        addr_d  = PADDR_W'(l1_full);
                    end
                end
            end
            L1: begin
                if (mem_busy) begin
                    ren_d = 1'b1;
                end else if (pte_ptr && ppn_fits(mem_rdata[31:10])) begin
                    state_d = L0;
                    ren_d   = 1'b1;
                    addr_d  = PADDR_W'(l0_full);
                end else begin
                    state_d = RESP;
                    done_d  = 1'b1;
                    fault_d = pte_fault | pte_ptr;
                    if (!pte_fault && !pte_ptr) begin
                        pte_d  = mem_rdata;
                        mega_d = 1'b1;
                    end
                end
            end
            L0: begin
                if (mem_busy) begin
                    ren_d = 1'b1;
                end else begin
                    state_d = RESP;
                    done_d  = 1'b1;
                    fault_d = pte_fault;
                    pte_d   = pte_fault ? 32'd0 : mem_rdata;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (walk_flush && state_q != IDLE) begin
            state_d = IDLE;
            ren_d   = 1'b0;
            done_d  = 1'b0;
            fault_d = 1'b0;
            pte_d   = 32'd0;
            mega_d  = 1'b0;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            vpn0_q     <= 10'd0;
            acc_q      <= 2'd0;
            priv_q     <= 2'd0;
            walk_busy  <= 1'b0;
            done_q     <= 1'b0;
            walk_fault <= 1'b0;
            walk_pte   <= 32'd0;
            walk_mega  <= 1'b0;
            mem_ren    <= 1'b0;
            mem_addr   <= '0;
        end else begin
            state_q    <= state_d;
            walk_busy  <= busy_d;
            done_q     <= done_d;
            walk_fault <= fault_d;
            walk_pte   <= pte_d;
            walk_mega  <= mega_d;
            mem_ren    <= ren_d;
            mem_addr   <= addr_d;
            if (latch_req) begin
                vpn0_q <= walk_vpn[9:0];
                acc_q  <= walk_acc;
                priv_q <= curr_privilege_level;
            end
        end
    end

endmodule
